regfile_wb_arbiter: RTL

- Shares the register file's single write port (ad3/we3/wd3) between two requesters:
  - the in-order pipeline writeback stage;
  - a long-latency unit (mul/div, load miss) that returns results out of band.
- Buffers one long-unit result and arbitrates with a starvation guard, stalling the pipeline when needed.
- Keeps a busy scoreboard of registers awaiting long-unit results, for hazard detection.
- Sits between the writeback stage, the long unit and the register file.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter between writeback and a long-latency unit
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_DEPTH  = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_wd,
    output logic                  wb_stall,
    input  logic                  lu_issue,
    input  logic [ADDR_WIDTH-1:0] lu_issue_rd,
    input  logic                  lu_valid,
    input  logic [ADDR_WIDTH-1:0] lu_rd,
    input  logic [DATA_WIDTH-1:0] lu_wd,
    output logic                  lu_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  we3,
    output logic [ADDR_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0] wd3
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_rd_q, buf_rd_d;
    logic [DATA_WIDTH-1:0] buf_wd_q, buf_wd_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [REG_DEPTH-1:0]  busy_q, busy_d;

    logic force_buf;
    logic grant_buf;
    logic handshake;

    // The buffered result has lost arbitration long enough; it now takes the port
    assign force_buf = buf_valid_q && (wait_cnt_q == MAX_CNT);

    // Ready depends only on registered state so the long unit sees no loop through lu_valid
    assign lu_ready  = !rst && !buf_valid_q;
    assign handshake = lu_valid && lu_ready;

    // Hazard lookup on the registered scoreboard; a committing write still reads busy this cycle
    assign rs1_busy = !rst && busy_q[rs1];
    assign rs2_busy = !rst && busy_q[rs2];

    // Write-port arbitration: forced buffer, then pipeline, then opportunistic buffer drain
    always_comb begin
        we3       = 1'b0;
        ad3       = '0;
        wd3       = '0;
        wb_stall  = 1'b0;
        grant_buf = 1'b0;
        if (rst) begin
            we3       = 1'b0;
        end else if (force_buf) begin
            grant_buf = 1'b1;
            we3       = 1'b1;
            ad3       = buf_rd_q;
            wd3       = buf_wd_q;
            wb_stall  = wb_we;
        end else if (wb_we && (wb_rd != '0)) begin
            we3       = 1'b1;
            ad3       = wb_rd;
            wd3       = wb_wd;
        end else if (buf_valid_q) begin
            grant_buf = 1'b1;
            we3       = 1'b1;
            ad3       = buf_rd_q;
            wd3       = buf_wd_q;
        end
    end

    // Next-state for the result buffer, starvation counter and scoreboard
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_wd_d    = buf_wd_q;
        wait_cnt_d  = '0;
        busy_d      = busy_q;

        // Grant and handshake are exclusive: one needs a full buffer, the other an empty one
        if (grant_buf) begin
            buf_valid_d = 1'b0;
        end
        if (handshake && (lu_rd != '0)) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = lu_rd;
            buf_wd_d    = lu_wd;
        end

        if (buf_valid_q && !grant_buf) begin
            wait_cnt_d = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 1'b1;
        end

        // Clear first so a same-index issue in the same cycle keeps the bit set
        if (grant_buf) begin
            busy_d[buf_rd_q] = 1'b0;
        end
        if (lu_issue && (lu_issue_rd != '0)) begin
            busy_d[lu_issue_rd] = 1'b1;
        end
    end

    // State registers; reset drops any buffered result and all pending scoreboard bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_wd_q    <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_wd_q    <= buf_wd_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
        end
    end

endmodule
